// File: rtl/board_mem_ctrl.sv
// Board BRAM owner: sequences parser writes, arbitrates solver reads, returns tagged read data.
// Optional BOARD_MEM_RD_DURING_LOAD_EN lets solver reads through during LOAD when no write is pending.
module board_mem_ctrl #(
  parameter int DATA_WIDTH   = 18,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  clear_board,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_grant,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_oor,
  output logic                  board_loaded,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  bram_en,
  output logic                  bram_regce,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {LOAD, SOLVE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] cnt_nxt;
  logic                loaded_nxt, ovf_nxt;
  logic                full, wr_fire, rd_oor_now;

  logic [READ_LATENCY:1] vld_pipe;
  logic [READ_LATENCY:1] oor_pipe;

  assign full       = (entry_count == FULL_CNT);
  assign wr_fire    = wr_valid && wr_ready;
  assign rd_oor_now = ({1'b0, rd_addr} >= entry_count);
  assign bram_regce = 1'b1;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = entry_count;
    loaded_nxt = board_loaded;
    ovf_nxt    = overflow;
    wr_ready   = 1'b0;
    rd_grant   = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    case (state)
      LOAD: begin
        wr_ready = !full && !clear_board;
        if (wr_valid && wr_ready) begin
          bram_en   = 1'b1;
          bram_we   = 1'b1;
          bram_addr = entry_count[ADDR_WIDTH-1:0];
          bram_din  = wr_data;
          cnt_nxt   = entry_count + 1'b1;
          if (wr_last) begin
            state_nxt  = SOLVE;
            loaded_nxt = 1'b1;
          end
        end else if (wr_valid && full && !clear_board) begin
          // Dropped entry; a terminating wr_last still closes the board.
          ovf_nxt = 1'b1;
          if (wr_last) begin
            state_nxt  = SOLVE;
            loaded_nxt = 1'b1;
          end
        end
`ifdef BOARD_MEM_RD_DURING_LOAD_EN
        rd_grant = rd_req && !(wr_valid && !full);
`else
        rd_grant = 1'b0;
`endif
      end
      SOLVE: begin
        rd_grant = rd_req;
      end
      default: state_nxt = LOAD;
    endcase
    if (rd_grant) begin
      bram_en   = 1'b1;
      bram_addr = rd_addr;
    end
    if (clear_board) begin
      state_nxt  = LOAD;
      cnt_nxt    = '0;
      loaded_nxt = 1'b0;
      ovf_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      entry_count  <= '0;
      board_loaded <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      entry_count  <= cnt_nxt;
      board_loaded <= loaded_nxt;
      overflow     <= ovf_nxt;
    end
  end

  // Valid/oor tags ride alongside the BRAM's internal read stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      oor_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_grant;
      oor_pipe[1] <= rd_grant && rd_oor_now;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        oor_pipe[i] <= oor_pipe[i-1];
      end
    end
  end

  assign rd_valid = vld_pipe[READ_LATENCY];
  assign rd_oor   = oor_pipe[READ_LATENCY];
  assign rd_data  = (rd_valid && !rd_oor) ? bram_dout : '0;

  logic unused_ok;
  assign unused_ok = wr_fire;

endmodule

// File: tb/tb_board_mem_ctrl.sv
// Directed bench for board_mem_ctrl: full-size instance plus a DEPTH=4 instance for overflow.
module tb_board_mem_ctrl;
  localparam int DW = 18;
  localparam int AW = 10;
  localparam int AW4 = 2;
`ifdef BOARD_MEM_RD_DURING_LOAD_EN
  localparam logic RD_IN_LOAD = 1'b1;
`else
  localparam logic RD_IN_LOAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // full-size instance
  logic          wr_valid, wr_last, wr_ready, clear_board, rd_req, rd_grant, rd_valid, rd_oor;
  logic [DW-1:0] wr_data, rd_data, bram_din, bram_dout;
  logic [AW-1:0] rd_addr, bram_addr;
  logic [AW:0]   entry_count;
  logic          board_loaded, overflow, bram_we, bram_en, bram_regce;

  board_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(1024), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .clear_board(clear_board), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data), .rd_oor(rd_oor),
    .board_loaded(board_loaded), .entry_count(entry_count), .overflow(overflow),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_en(bram_en),
    .bram_regce(bram_regce), .bram_dout(bram_dout));

  // DEPTH=4 instance
  logic           b_wr_valid, b_wr_last, b_wr_ready, b_clear, b_rd_req, b_rd_grant, b_rd_valid, b_rd_oor;
  logic [DW-1:0]  b_wr_data, b_rd_data, b_bram_din, b_bram_dout;
  logic [AW4-1:0] b_rd_addr, b_bram_addr;
  logic [AW4:0]   b_entry_count;
  logic           b_loaded, b_overflow, b_bram_we, b_bram_en, b_bram_regce;

  board_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(4), .READ_LATENCY(2)) dut4 (
    .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_last(b_wr_last),
    .wr_ready(b_wr_ready), .clear_board(b_clear), .rd_req(b_rd_req), .rd_addr(b_rd_addr),
    .rd_grant(b_rd_grant), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_oor(b_rd_oor),
    .board_loaded(b_loaded), .entry_count(b_entry_count), .overflow(b_overflow),
    .bram_addr(b_bram_addr), .bram_din(b_bram_din), .bram_we(b_bram_we), .bram_en(b_bram_en),
    .bram_regce(b_bram_regce), .bram_dout(b_bram_dout));

  // Two-cycle registered-read BRAM models
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] mem4 [4];
  logic [DW-1:0] r1, r1_4;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         r1 <= mem[bram_addr];
    end
    if (bram_regce) bram_dout <= r1;
  end

  always @(posedge clk) begin
    if (b_bram_en) begin
      if (b_bram_we) mem4[b_bram_addr] <= b_bram_din;
      else           r1_4 <= mem4[b_bram_addr];
    end
    if (b_bram_regce) b_bram_dout <= r1_4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_valid = 0; wr_data = '0; wr_last = 0; clear_board = 0; rd_req = 0; rd_addr = '0;
    b_wr_valid = 0; b_wr_data = '0; b_wr_last = 0; b_clear = 0; b_rd_req = 0; b_rd_addr = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 18'h2ABCD ^ DW'(i);
    for (int i = 0; i < 4; i++) mem4[i] = 18'h15555;
    r1 = '0; r1_4 = '0; bram_dout = '0; b_bram_dout = '0;
    rst = 1'b1;
    idle();
    repeat (2) step();
    #1;
    chk("rst_count", entry_count, 0);
    chk("rst_loaded", board_loaded, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_oor", rd_oor, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_regce", bram_regce, 1);
    step(); rst = 1'b0;

    // three writes, read requested alongside the first
    step(); wr_valid = 1; wr_data = 18'h00011; rd_req = 1; rd_addr = 0; #1;
    chk("w1_ready", wr_ready, 1);
    chk("w1_we", bram_we, 1);
    chk("w1_en", bram_en, 1);
    chk("w1_addr", bram_addr, 0);
    chk("w1_din", bram_din, 18'h00011);
    chk("w1_rd_grant", rd_grant, 0);
    step(); wr_data = 18'h00022; rd_req = 0; #1;
    chk("w2_addr", bram_addr, 1);
    chk("w2_count", entry_count, 1);
    step(); wr_data = 18'h00033; wr_last = 1; #1;
    chk("w3_addr", bram_addr, 2);
    chk("w3_din", bram_din, 18'h00033);
    chk("w3_loaded", board_loaded, 0);

    // SOLVE: write ignored, back-to-back reads 2,0,1 (first read in the board_loaded-rise cycle)
    step(); wr_valid = 1; wr_data = 18'h3FFFF; wr_last = 0; rd_req = 1; rd_addr = 2; #1;
    chk("s_loaded", board_loaded, 1);
    chk("s_count", entry_count, 3);
    chk("s_wr_ready", wr_ready, 0);
    chk("s_we", bram_we, 0);
    chk("r2_grant", rd_grant, 1);
    chk("r2_addr", bram_addr, 2);
    step(); wr_valid = 0; rd_addr = 0; #1;
    chk("r_n1_valid", rd_valid, 0);
    step(); rd_addr = 1; #1;
    chk("r_n2_valid", rd_valid, 1);
    chk("r_n2_data", rd_data, 18'h00033);
    chk("r_n2_oor", rd_oor, 0);
    step(); rd_req = 0; #1;
    chk("r_n3_valid", rd_valid, 1);
    chk("r_n3_data", rd_data, 18'h00011);
    chk("r_idle_en", bram_en, 0);
    step(); #1;
    chk("r_n4_valid", rd_valid, 1);
    chk("r_n4_data", rd_data, 18'h00022);
    step(); #1;
    chk("r_n5_valid", rd_valid, 0);

    // out-of-range read
    step(); rd_req = 1; rd_addr = 5; #1;
    chk("oor_grant", rd_grant, 1);
    step(); rd_req = 0; #1;
    step(); #1;
    chk("oor_valid", rd_valid, 1);
    chk("oor_data", rd_data, 0);
    chk("oor_flag", rd_oor, 1);

    // clear_board with a read in flight
    step(); rd_req = 1; rd_addr = 1; #1;
    step(); rd_req = 0; clear_board = 1; wr_valid = 1; wr_data = 18'h00055; #1;
    chk("clr_wr_ready", wr_ready, 0);
    chk("clr_we", bram_we, 0);
    step(); clear_board = 0; wr_valid = 0; #1;
    chk("clr_rd_valid", rd_valid, 1);
    chk("clr_rd_data", rd_data, 18'h00022);
    chk("clr_rd_oor", rd_oor, 0);
    chk("clr_count", entry_count, 0);
    chk("clr_loaded", board_loaded, 0);
    chk("clr_wr_ready_next", wr_ready, 1);

    // LOAD arbitration: write wins, read follows when the write stops
    step(); wr_valid = 1; wr_data = 18'h00044; rd_req = 1; rd_addr = 0; #1;
    chk("arb_we", bram_we, 1);
    chk("arb_grant_w", rd_grant, 0);
    step(); wr_valid = 0; #1;
    chk("arb_grant_idle", rd_grant, RD_IN_LOAD);
    chk("arb_count", entry_count, 1);
    step(); rd_req = 0; clear_board = 1; wr_valid = 1; wr_data = 18'h00077; #1;
    chk("ld_clr_wr_ready", wr_ready, 0);
    chk("ld_clr_we", bram_we, 0);
    step(); clear_board = 0; wr_valid = 0; #1;
    chk("arb_rd_valid", rd_valid, RD_IN_LOAD);
    chk("arb_rd_data", rd_data, RD_IN_LOAD ? 18'h00044 : 18'h0);
    chk("ld_clr_count", entry_count, 0);
    step(); wr_valid = 1; wr_data = 18'h00066; wr_last = 1; #1;
    chk("l1_addr", bram_addr, 0);
    chk("l1_we", bram_we, 1);
    step(); wr_valid = 0; wr_last = 0; rd_req = 1; rd_addr = 0; #1;
    chk("l1_loaded", board_loaded, 1);
    chk("l1_grant", rd_grant, 1);
    step(); rd_req = 0; #1;
    step(); #1;
    chk("l1_rd_valid", rd_valid, 1);
    chk("l1_rd_data", rd_data, 18'h00066);

    // reset while a read is in flight
    step(); rd_req = 1; rd_addr = 0; #1;
    step(); rd_req = 0; rst = 1; #1;
    step(); #1;
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_loaded", board_loaded, 0);
    chk("mrst_count", entry_count, 0);
    step(); rst = 0;

    // DEPTH=4 overflow
    for (int i = 0; i < 5; i++) begin
      step(); b_wr_valid = 1; b_wr_data = DW'(18'h00100 + i); b_wr_last = (i == 4); #1;
      chk("ov_wr_ready", b_wr_ready, (i < 4) ? 1 : 0);
      chk("ov_we", b_bram_we, (i < 4) ? 1 : 0);
      if (i == 4) chk("ov_pre_flag", b_overflow, 0);
    end
    step(); b_wr_valid = 0; b_wr_last = 0; b_rd_req = 1; b_rd_addr = 3; #1;
    chk("ov_flag", b_overflow, 1);
    chk("ov_loaded", b_loaded, 1);
    chk("ov_count", b_entry_count, 4);
    chk("ov_grant", b_rd_grant, 1);
    step(); b_rd_req = 0; #1;
    step(); #1;
    chk("ov_rd_valid", b_rd_valid, 1);
    chk("ov_rd_data", b_rd_data, 18'h00103);
    chk("ov_rd_oor", b_rd_oor, 0);
    step(); b_clear = 1; #1;
    step(); b_clear = 0; #1;
    chk("ov_clr_flag", b_overflow, 0);
    chk("ov_clr_ready", b_wr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
